// File: rtl/hc_seq_pkg.sv
// Shared types and helpers for the HC174 bank load sequencer.
package hc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Clock cycles spent on one bank: setup, strobe high time and one hold cycle.
    function automatic int bank_cycles(input int setup_cyc, input int strobe_cyc);
        return setup_cyc + strobe_cyc + 1;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hc_seq_timer.sv
// Loadable down-counter with a zero flag, used to time state durations.
module hc_seq_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load a new duration or count down towards zero and stop there.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/hc174_load_sequencer.sv
// Walks enabled HC174 banks in ascending order, strobing each bank's clock pin
// while the shared bus select points at it, and issues timed bulk clears.
module hc174_load_sequencer
    import hc_seq_pkg::*;
#(
    parameter int BANKS      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int CLR_CYC    = 2,
    localparam int SELW      = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_clr_req,
    input  logic [BANKS-1:0] i_bank_mask,
    output logic [SELW-1:0]  o_sel,
    output logic [BANKS-1:0] o_strobe,
    output logic             o_nclr,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] STROBE_LD = 16'(STROBE_CYC - 1);
    localparam logic [15:0] CLR_LD    = 16'(CLR_CYC - 1);

    state_t           r_state;
    logic [BANKS-1:0] r_pending;
    logic [SELW-1:0]  r_sel;
    logic [BANKS-1:0] r_strobe;
    logic             r_nclr;
    logic             r_busy;
    logic             r_done;

    state_t           w_next;
    logic [BANKS-1:0] w_nextPending;
    logic [SELW-1:0]  w_nextSel;
    logic [BANKS-1:0] w_strobeNext;
    logic [7:0]       w_maskPad;
    logic [7:0]       w_pendPad;
    logic             w_timerLoad;
    logic [15:0]      w_timerValue;
    logic             w_timerZero;

    hc_seq_timer #(.W(16)) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_timerLoad),
        .i_value (w_timerValue),
        .o_zero  (w_timerZero)
    );

    // Next state, pending set, select and timer reload for the coming edge.
    always_comb begin
        w_next        = r_state;
        w_nextPending = r_pending;
        w_nextSel     = r_sel;
        w_timerLoad   = 1'b0;
        w_timerValue  = '0;
        w_maskPad     = '0;
        w_maskPad[BANKS-1:0] = i_bank_mask;
        w_pendPad     = '0;
        w_pendPad[BANKS-1:0] = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_next       = ST_CLEAR;
                    w_timerLoad  = 1'b1;
                    w_timerValue = CLR_LD;
                end else if (i_start) begin
                    w_nextPending = i_bank_mask;
                    if (i_bank_mask == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next       = ST_SETUP;
                        w_nextSel    = SELW'(lowest_set(w_maskPad));
                        w_timerLoad  = 1'b1;
                        w_timerValue = SETUP_LD;
                    end
                end
            end
            ST_CLEAR: begin
                if (w_timerZero) w_next = ST_DONE;
            end
            ST_SETUP: begin
                if (w_timerZero) begin
                    w_next       = ST_STROBE;
                    w_timerLoad  = 1'b1;
                    w_timerValue = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (w_timerZero) begin
                    w_next = ST_GAP;
                    w_nextPending[r_sel] = 1'b0;
                end
            end
            ST_GAP: begin
                if (r_pending != '0) begin
                    w_next       = ST_SETUP;
                    w_nextSel    = SELW'(lowest_set(w_pendPad));
                    w_timerLoad  = 1'b1;
                    w_timerValue = SETUP_LD;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Only the bank being visited may see its clock pin high, and only in STROBE.
    always_comb begin
        w_strobeNext = '0;
        if (w_next == ST_STROBE) w_strobeNext[w_nextSel] = 1'b1;
    end

    // Register state and all outputs so the bank pins are glitch-free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_sel     <= '0;
            r_strobe  <= '0;
            r_nclr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_nextPending;
            r_sel     <= w_nextSel;
            r_strobe  <= w_strobeNext;
            r_nclr    <= (w_next != ST_CLEAR);
            r_busy    <= (w_next == ST_CLEAR) || (w_next == ST_SETUP) ||
                         (w_next == ST_STROBE) || (w_next == ST_GAP);
            r_done    <= (w_next == ST_DONE);
        end
    end

    assign o_sel    = r_sel;
    assign o_strobe = r_strobe;
    assign o_nclr   = r_nclr;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_hc174_load_sequencer.sv
// Randomized bench for hc174_load_sequencer with four behavioural HC174 banks.
module tb_hc174_load_sequencer;

    localparam int S = 1;
    localparam int P = 2;
    localparam int C = 2;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_clr_req;
    logic [3:0] i_bank_mask;
    logic [1:0] o_sel;
    logic [3:0] o_strobe;
    logic       o_nclr;
    logic       o_busy;
    logic       o_done;

    int checkCount;
    int failCount;

    logic [8:0] expQ[$];
    logic [1:0] lastSel;
    logic [5:0] offset;
    logic [5:0] bus;
    logic [5:0] bankQ[4];
    logic [5:0] bankExp[4];
    logic [3:0] prevStb;

    hc174_load_sequencer #(
        .BANKS(4), .SETUP_CYC(S), .STROBE_CYC(P), .CLR_CYC(C)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (i_start),
        .i_clr_req   (i_clr_req),
        .i_bank_mask (i_bank_mask),
        .o_sel       (o_sel),
        .o_strobe    (o_strobe),
        .o_nclr      (o_nclr),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared data bus driven from the select: each source has a distinct value.
    assign bus = 6'(o_sel) + offset;

    // Four HC174 banks: clk-sampled edge detector on p9, clear on p1 low.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            prevStb[b] <= o_strobe[b];
            if (!o_nclr) bankQ[b] <= 6'h00;
            else if (o_strobe[b] && !prevStb[b]) bankQ[b] <= bus;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [8:0] obsVec();
        return {o_busy, o_done, o_nclr, o_strobe, o_sel};
    endfunction

    function automatic logic [8:0] idleRow();
        return {1'b0, 1'b0, 1'b1, 4'b0000, lastSel};
    endfunction

    // Expected per-cycle outputs of a load: each set bit, lowest first.
    task automatic buildLoadRows(input logic [3:0] mask);
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                repeat (S) expQ.push_back({1'b1, 1'b0, 1'b1, 4'b0000, 2'(b)});
                repeat (P) expQ.push_back({1'b1, 1'b0, 1'b1, 4'(1 << b), 2'(b)});
                expQ.push_back({1'b1, 1'b0, 1'b1, 4'b0000, 2'(b)});
                lastSel = 2'(b);
                bankExp[b] = 6'(b) + offset;
            end
        end
        expQ.push_back({1'b0, 1'b1, 1'b1, 4'b0000, lastSel});
    endtask

    task automatic buildClearRows();
        repeat (C) expQ.push_back({1'b1, 1'b0, 1'b0, 4'b0000, lastSel});
        expQ.push_back({1'b0, 1'b1, 1'b1, 4'b0000, lastSel});
        for (int b = 0; b < 4; b++) bankExp[b] = 6'h00;
    endtask

    // Issue one request, follow it cycle by cycle with ignored pokes, check banks.
    task automatic applyStimulus(input logic [3:0] mask, input logic clr,
                                 input logic st, input logic [5:0] off);
        string tag;
        offset = off;
        expQ.delete();
        if (clr) begin
            buildClearRows();
            tag = "clear";
        end else begin
            buildLoadRows(mask);
            tag = "load";
        end
        i_bank_mask = mask;
        i_clr_req   = clr;
        i_start     = st;
        @(posedge clk); #1;
        i_start   = 1'b0;
        i_clr_req = 1'b0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            checkOutput(tag, 32'(obsVec()), 32'(expQ[i]));
            if (i < expQ.size() - 1) begin
                i_start     = ($urandom_range(0, 2) == 0);
                i_clr_req   = ($urandom_range(0, 3) == 0);
                i_bank_mask = 4'($urandom);
            end else begin
                i_start   = 1'b0;
                i_clr_req = 1'b0;
            end
        end
        for (int b = 0; b < 4; b++) checkOutput("bank", 32'(bankQ[b]), 32'(bankExp[b]));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            checkOutput("idle", 32'(obsVec()), 32'(idleRow()));
        end
    endtask

    initial begin
        int waitCnt;
        checkCount  = 0;
        failCount   = 0;
        lastSel     = 2'd0;
        offset      = 6'h11;
        prevStb     = '0;
        for (int b = 0; b < 4; b++) begin
            bankQ[b]   = 6'h00;
            bankExp[b] = 6'h00;
        end
        rst         = 1'b1;
        i_start     = 1'b0;
        i_clr_req   = 1'b0;
        i_bank_mask = 4'h0;

        // Reset held: everything low, including nclr.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 32'(obsVec()), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("nclrRelease", 32'(obsVec()), 32'(idleRow()));
        for (int b = 0; b < 4; b++) checkOutput("bankReset", 32'(bankQ[b]), 32'h0);

        // Directed cases: full, sparse, empty, clear winning over start.
        applyStimulus(4'b1111, 1'b0, 1'b1, 6'h11);
        idleCycles(1);
        applyStimulus(4'b1010, 1'b0, 1'b1, 6'h21);
        idleCycles(1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 6'h05);
        idleCycles(2);
        applyStimulus(4'b1111, 1'b1, 1'b1, 6'h30);
        idleCycles(3);

        // Reset while bank 2 is strobing.
        offset      = 6'h08;
        i_bank_mask = 4'b0100;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        waitCnt = 0;
        while (!o_strobe[2] && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("strobe2Seen", 32'(o_strobe[2]), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncReset", 32'(obsVec()), 32'h0);
        lastSel = 2'd0;
        for (int b = 0; b < 4; b++) bankExp[b] = 6'h00;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycles(1);
        for (int b = 0; b < 4; b++) checkOutput("bankAfterRst", 32'(bankQ[b]), 32'h0);
        applyStimulus(4'b0100, 1'b0, 1'b1, 6'h0C);
        idleCycles(1);

        // Randomized requests with random idle gaps.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0)
                applyStimulus(4'($urandom), 1'b1, 1'($urandom), 6'($urandom));
            else
                applyStimulus(4'($urandom), 1'b0, 1'b1, 6'($urandom));
            idleCycles($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
